// File: rtl/mio_dmem_responder_pkg.sv
// Shared encodings for the MIO data-memory responder: DM_CTRL access
// codes, responder FSM states and an access-size decode helper.
package mio_dmem_responder_pkg;

    // DM_CTRL access size/sign codes; 101-111 behave as word accesses
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    function automatic size_e dm_size(input logic [2:0] ctrl);
        case (ctrl)
            DM_BYTE, DM_BYTE_U: return SZ_BYTE;
            DM_HALF, DM_HALF_U: return SZ_HALF;
            default:            return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mio_dmem_responder_lane.sv
// dmem_lane_unit: combinational little-endian lane logic. Merges store
// data into the addressed word and extracts/extends load data. Low
// address bits are forced to the access alignment; the misaligned flag
// reports when that forcing was needed.
module dmem_lane_unit
    import mio_dmem_responder_pkg::*;
(
    input  logic [2:0]  dm_ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] new_word,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [3:0]  be;
    logic [31:0] wrep;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane selection, store merge and load extension
    always_comb begin
        be         = '0;
        wrep       = wdata;
        rdata      = old_word;
        misaligned = 1'b0;
        byte_v     = old_word[8*addr_lo +: 8];
        half_v     = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        case (dm_size(dm_ctrl))
            SZ_BYTE: begin
                be            = 4'b0001 << addr_lo;
                wrep          = {4{wdata[7:0]}};
                rdata         = (dm_ctrl == DM_BYTE) ? {{24{byte_v[7]}}, byte_v}
                                                     : {24'h0, byte_v};
            end
            SZ_HALF: begin
                be            = addr_lo[1] ? 4'b1100 : 4'b0011;
                wrep          = {2{wdata[15:0]}};
                rdata         = (dm_ctrl == DM_HALF) ? {{16{half_v[15]}}, half_v}
                                                     : {16'h0, half_v};
                misaligned    = addr_lo[0];
            end
            default: begin
                be            = 4'b1111;
                misaligned    = |addr_lo;
            end
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            new_word[8*i +: 8] = be[i] ? wrep[8*i +: 8] : old_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/mio_dmem_responder.sv
// mio_dmem_responder: single-outstanding data-memory slave for the CPU
// MIO port with WAIT_CYCLES programmable wait states.
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned half/word accesses
// raise err with MIO_ready, suppress the store and return zero.
module mio_dmem_responder
    import mio_dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Wdata_in,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] Rdata_out,
    output logic        MIO_ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e            state;
    logic [3:0]        cnt;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        ctrl_q;
    logic              we_q;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W+1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [2:0]        acc_ctrl;
    logic              acc_we;
    logic              go_resp;
    logic              acc_misal;
    logic              acc_bad;
    logic [31:0]       old_word;
    logic [31:0]       new_word;
    logic [31:0]       load_val;
    logic              unused_bits;

    // With zero wait states the access completes on the accepting edge,
    // so the live inputs feed the datapath in IDLE, captured copies otherwise
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_ctrl  = ctrl_q;
        acc_we    = we_q;
        if (state == S_IDLE) begin
            acc_addr  = Addr_in[ADDR_W+1:0];
            acc_wdata = Wdata_in;
            acc_ctrl  = dm_ctrl;
            acc_we    = mem_w;
        end
        go_resp  = ((state == S_IDLE) && CPU_MIO && (WAIT_CYCLES == 0)) ||
                   ((state == S_WAIT) && (cnt == '0));
        old_word = mem[acc_addr[ADDR_W+1:2]];
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign acc_bad     = acc_misal;
    assign unused_bits = ^Addr_in[31:ADDR_W+2];
`else
    assign acc_bad     = 1'b0;
    assign unused_bits = ^{Addr_in[31:ADDR_W+2], acc_misal};
`endif

    dmem_lane_unit u_lane (
        .dm_ctrl    (acc_ctrl),
        .addr_lo    (acc_addr[1:0]),
        .wdata      (acc_wdata),
        .old_word   (old_word),
        .new_word   (new_word),
        .rdata      (load_val),
        .misaligned (acc_misal)
    );

    // Store commit on the edge entering RESP; array is never cleared
    always_ff @(posedge clk) begin
        if (!reset && go_resp && acc_we && !acc_bad) begin
            mem[acc_addr[ADDR_W+1:2]] <= new_word;
        end
    end

    // Request/wait/response sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            Rdata_out <= '0;
            MIO_ready <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            MIO_ready <= 1'b0;
            if (go_resp) begin
                state     <= S_RESP;
                MIO_ready <= 1'b1;
                busy      <= 1'b1;
                err       <= acc_bad;
                Rdata_out <= acc_bad ? '0 : load_val;
            end
            case (state)
                S_IDLE: begin
                    if (CPU_MIO) begin
                        addr_q  <= Addr_in[ADDR_W+1:0];
                        wdata_q <= Wdata_in;
                        ctrl_q  <= dm_ctrl;
                        we_q    <= mem_w;
                        busy    <= 1'b1;
                        if (WAIT_CYCLES != 0) begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_dmem_responder.sv
// Scoreboard bench for mio_dmem_responder: directed and random accesses
// against a byte-lane reference model, plus back-to-back throughput on
// zero- and three-wait-state instances.
module tb_mio_dmem_responder;

    localparam int unsigned W1    = 1;
    localparam int unsigned DEPTH = 1024;

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        bit          err;
        int          ready_cyc;
    } exp_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        CPU_MIO = 0;
    logic        mem_w = 0;
    logic [31:0] Addr_in = 0;
    logic [31:0] Wdata_in = 0;
    logic [2:0]  dm_ctrl = 0;
    logic [31:0] Rdata_out;
    logic        MIO_ready, busy, err;

    logic        tp_req = 0;
    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3, busy0, busy3, err0, err3;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last0 = -1, last3 = -1, n0 = 0, n3 = 0;
    exp_t sb[$];
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mio_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(W1)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_in(Addr_in), .Wdata_in(Wdata_in), .dm_ctrl(dm_ctrl),
        .Rdata_out(Rdata_out), .MIO_ready(MIO_ready), .busy(busy), .err(err)
    );

    mio_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .CPU_MIO(tp_req), .mem_w(1'b0),
        .Addr_in(32'h0), .Wdata_in(32'h0), .dm_ctrl(3'b000),
        .Rdata_out(rd0), .MIO_ready(rdy0), .busy(busy0), .err(err0)
    );

    mio_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .CPU_MIO(tp_req), .mem_w(1'b0),
        .Addr_in(32'h4), .Wdata_in(32'h0), .dm_ctrl(3'b000),
        .Rdata_out(rd3), .MIO_ready(rdy3), .busy(busy3), .err(err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory with aligned-down offsets
    function automatic void model_access(input logic [2:0] c, input logic [31:0] a,
                                         input logic [31:0] d, input logic w,
                                         output logic [31:0] r, output bit er);
        int unsigned idx;
        int unsigned off;
        int unsigned nbytes;
        logic [31:0] mask;
        logic [31:0] v;
        idx = (a >> 2) % DEPTH;
        off = a % 4;
        if (c == 3 || c == 4)      nbytes = 1;
        else if (c == 1 || c == 2) nbytes = 2;
        else                       nbytes = 4;
        er = 0;
`ifdef DMEM_MISALIGN_ERR_EN
        if (off % nbytes != 0) er = 1;
`endif
        off = off - (off % nbytes);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1);
        v = (model_mem[idx] >> (8 * off)) & mask;
        if ((c == 1 || c == 3) && v[8 * nbytes - 1]) v = v | ~mask;
        r = v;
        if (er) r = 0;
        else if (w) model_mem[idx] = (model_mem[idx] & ~(mask << (8 * off))) |
                                     ((d & mask) << (8 * off));
    endfunction

    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input bit use_k, input logic [31:0] k);
        exp_t e;
        logic [31:0] r;
        bit er;
        @(negedge clk);
        CPU_MIO = 1; mem_w = w; Addr_in = a; Wdata_in = d; dm_ctrl = c;
        model_access(c, a, d, w, r, er);
        @(posedge clk);
        #1;
        CPU_MIO = 0;
        e.is_load   = !w;
        e.rdata     = use_k ? k : r;
        e.err       = er;
        e.ready_cyc = cyc + W1;
        sb.push_back(e);
        check("busy_after_accept", {31'h0, busy}, 32'h1);
        repeat (W1 + 1) @(posedge clk);
    endtask

    // Main-DUT monitor: pops one expectation per MIO_ready strobe
    always @(negedge clk) begin
        if (MIO_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ready_latency", cyc, e.ready_cyc);
                check("err", {31'h0, err}, {31'h0, e.err});
                check("busy_with_ready", {31'h0, busy}, 32'h1);
                if (e.is_load) check("rdata", Rdata_out, e.rdata);
            end
        end
    end

    // Throughput monitor for the zero- and three-wait instances
    always @(negedge clk) begin
        if (rdy0) begin
            if (last0 >= 0) check("w0_spacing", cyc - last0, 2);
            check("w0_busy", {31'h0, busy0}, 32'h1);
            last0 = cyc;
            n0++;
        end
        if (rdy3) begin
            if (last3 >= 0) check("w3_spacing", cyc - last3, 5);
            check("w3_busy", {31'h0, busy3}, 32'h1);
            last3 = cyc;
            n3++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_rdata", Rdata_out, 32'h0);
        check("reset_ready", {31'h0, MIO_ready}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);

        // Fill the word pool 0x00..0x7F so every later read is known
        for (int i = 0; i < 32; i++) issue(3'b000, 32'(i * 4), $urandom, 1, 0, 0);

        issue(3'b000, 32'h10, 32'hDEADBEEF, 1, 0, 0);
        issue(3'b000, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF);
        issue(3'b000, 32'h10, 32'h11223344, 1, 0, 0);
        issue(3'b011, 32'h13, 32'h00000080, 1, 0, 0);
        issue(3'b011, 32'h13, 32'h0, 0, 1, 32'hFFFFFF80);
        issue(3'b100, 32'h13, 32'h0, 0, 1, 32'h00000080);
        issue(3'b000, 32'h10, 32'h0, 0, 1, 32'h80223344);
        issue(3'b000, 32'h20, 32'h0, 1, 0, 0);
        issue(3'b001, 32'h22, 32'h0000ABCD, 1, 0, 0);
        issue(3'b001, 32'h22, 32'h0, 0, 1, 32'hFFFFABCD);
        issue(3'b010, 32'h22, 32'h0, 0, 1, 32'h0000ABCD);
        issue(3'b000, 32'h20, 32'h0, 0, 1, 32'hABCD0000);
        issue(3'b111, 32'hFFFF_F020, 32'h0, 0, 1, 32'hABCD0000);

        // Reset while a store waits: no response, store discarded
        issue(3'b000, 32'h40, 32'h12345678, 1, 0, 0);
        @(negedge clk);
        CPU_MIO = 1; mem_w = 1; Addr_in = 32'h40; Wdata_in = 32'h5; dm_ctrl = 3'b000;
        @(posedge clk);
        #1 CPU_MIO = 0; reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("busy_after_abort", {31'h0, busy}, 32'h0);
        repeat (4) @(posedge clk);
        issue(3'b000, 32'h40, 32'h0, 0, 1, 32'h12345678);

        // Misaligned word store
        issue(3'b000, 32'h41, 32'hCAFEF00D, 1, 0, 0);
`ifdef DMEM_MISALIGN_ERR_EN
        issue(3'b000, 32'h40, 32'h0, 0, 1, 32'h12345678);
`else
        issue(3'b000, 32'h40, 32'h0, 0, 1, 32'hCAFEF00D);
`endif

        for (int i = 0; i < 80; i++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            d = $urandom;
            issue(3'($urandom_range(0, 7)), a, d, 1'($urandom_range(0, 1)), 0, 0);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        @(negedge clk);
        tp_req = 1;
        repeat (40) @(posedge clk);
        #1 tp_req = 0;
        repeat (10) @(posedge clk);
        check("w0_strobes", n0, 20);
        check("w3_strobes", n3, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mio_dmem_responder.md
Name: mio_dmem_responder

Overview:
Data-memory responder for the CPU's MIO data port. Accepts one load/store request at a time from the pipeline (CPU_MIO, mem_w, Addr_out, Data_out, dm_ctrl) and applies DM_CTRL byte/halfword/word lane rules against an internal word array. Inserts a programmable number of wait states, then returns read data and pulses MIO_ready. Sits between the CPU core and the SoC bus as the data-side slave.

Parameters:
ADDR_W, 10, word-address bits; array depth = 2**ADDR_W 32-bit words
WAIT_CYCLES, 1, wait states inserted between acceptance and response (0..15)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
CPU_MIO  input  1  request valid from CPU
mem_w  input  1  1 = store, 0 = load; sampled with CPU_MIO
Addr_in  input  32  byte address from CPU (Addr_out of core)
Wdata_in  input  32  store data from CPU, LSB-aligned (Data_out of core)
dm_ctrl  input  3  access size/sign, DM_CTRL encoding
Rdata_out  output  32  load result, sign/zero extended; drives core Data_in
MIO_ready  output  1  one-cycle response strobe
busy  output  1  high from acceptance until the MIO_ready cycle inclusive
err  output  1  misalignment flag, valid with MIO_ready (see Optional Feature)

Behaviour:
- Clock clk, reset reset: one clock; reset is synchronous and active-high.
- Reset values: Rdata_out=0, MIO_ready=0, busy=0, err=0, FSM=IDLE, wait counter=0. Array contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if CPU_MIO=1, capture Addr_in, Wdata_in, dm_ctrl, mem_w; go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else RESP. busy rises on that edge.
- WAIT: decrement counter; at 0 go to RESP. Inputs ignored.
- RESP: MIO_ready=1, busy=1 for exactly one cycle; next state IDLE. Rdata_out is registered on the edge entering RESP and holds until the next RESP entry.
- Latency: request sampled at edge N -> MIO_ready high in cycle N+1+WAIT_CYCLES. Throughput: one access per WAIT_CYCLES+2 cycles. A CPU_MIO still high in IDLE after RESP is a new request.
- Stores commit to the array on the edge entering RESP; loads read the array at the same edge (pre-store value irrelevant, single outstanding access).
- Word index = Addr_in[ADDR_W+1:2]; higher address bits ignored (aliasing/wrap).
- Little-endian lanes. DM_CTRL: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 treated as word.
- Store byte writes Wdata_in[7:0] to lane Addr_in[1:0]; half writes Wdata_in[15:0] to lanes selected by Addr_in[1]; other lanes unchanged.
- Load byte/half extracts lane and sign- or zero-extends to 32 bits.
- Misaligned without macro: low bits forced aligned (half uses Addr_in[1], word ignores Addr_in[1:0]); err tied 0.
- reset during WAIT or RESP: returns to IDLE next edge, pending store discarded, MIO_ready not issued.

Optional Feature:
Macro DMEM_MISALIGN_ERR_EN. Defined: half access with Addr_in[0]=1, or word access with Addr_in[1:0]!=0, completes normally in timing but err=1 with MIO_ready, store suppressed, Rdata_out=0. Undefined: alignment forcing as above, err constant 0.

Decomposition:
- Shared package/include: DM_CTRL encodings (DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U), FSM state encodings.
- One sub-module: dmem_lane_unit (combinational) — store byte-enable/merge and load extract/extend from dm_ctrl and Addr[1:0]; FSM and array stay in top.

Test Plan:
- Reset then sw 0xDEADBEEF @0x10, lw @0x10, WAIT_CYCLES=1 -> MIO_ready 2 cycles after each acceptance, Rdata_out=0xDEADBEEF.
- sb 0x80 @0x13 over 0x11223344 then lb @0x13 -> 0xFFFFFF80; lbu -> 0x00000080; lw -> 0x80223344.
- sh 0xABCD @0x22 over 0 then lh -> 0xFFFFABCD, lhu -> 0x0000ABCD, lw @0x20 -> 0xABCD0000.
- WAIT_CYCLES=0 and 3 with CPU_MIO held high -> strobes every 2 and 5 cycles respectively, busy never low between.
- reset asserted in WAIT during sw 0x5 @0x40 -> no MIO_ready, later lw @0x40 returns prior value.
- With DMEM_MISALIGN_ERR_EN: sw @0x41 -> err=1 with MIO_ready, array unchanged; without: writes word @0x40.
